// File: rtl/ifetch_unit.sv
// ifetch_unit
//
// Instruction fetch unit. It owns the architectural PC and issues one word
// fetch at a time to instruction memory over a req/gnt/rvalid handshake. The
// returned word is registered and offered to decode over a valid/ready
// handshake. On each decode handshake the externally computed next PC (npc)
// is loaded and the next fetch begins. A misaligned npc parks the unit in a
// sticky fault state that only reset clears.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   imem_req     fetch request, high only while issuing
//   imem_addr    fetch address (always the current pc)
//   imem_gnt     memory accepted the request
//   imem_rvalid  fetched word valid
//   imem_rdata   fetched word
//   inst_valid   registered instruction available to decode
//   inst         registered instruction word
//   inst_pc      PC of inst
//   inst_ready   decode consumes inst this cycle
//   npc          next PC, sampled only on the decode handshake
//   pc           current PC register
//   misalign     sticky: a handshaked npc was not word aligned

module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic [31:0] npc,
    output logic [31:0] pc,
    output logic        misalign
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StIssue = 3'd1;
    localparam logic [2:0] StWait  = 3'd2;
    localparam logic [2:0] StHold  = 3'd3;
    localparam logic [2:0] StFault = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        misalign_q, misalign_d;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        misalign_d = misalign_q;
        case (state_q)
            StIdle: begin
                state_d = StIssue;
            end
            StIssue: begin
                if (imem_gnt) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (imem_rvalid) begin
                    inst_d    = imem_rdata;
                    inst_pc_d = pc_q;
                    state_d   = StHold;
                end
            end
            StHold: begin
                if (inst_ready) begin
                    if (npc[1:0] == 2'b00) begin
                        pc_d    = npc;
                        state_d = StIssue;
                    end else begin
                        // pc is kept so the faulting instruction's PC stays visible
                        misalign_d = 1'b1;
                        state_d    = StFault;
                    end
                end
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            inst_q     <= 32'h0000_0000;
            inst_pc_q  <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            misalign_q <= misalign_d;
        end
    end

    // Handshake outputs decode purely from registered state.
    assign imem_req   = (state_q == StIssue);
    assign inst_valid = (state_q == StHold);
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign misalign   = misalign_q;

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic [31:0] npc;
    logic [31:0] pc;
    logic        misalign;

    int tests_run;
    int tests_failed;

    ifetch_unit #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready),
        .npc        (npc),
        .pc         (pc),
        .misalign   (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are then sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        inst_ready = 1'b0; npc = 32'h0;
        step();
        step();
        tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
        tests_run++; if (pc !== 32'h0) begin tests_failed++; $display("FAIL reset_pc got=%h exp=0", pc); end
        tests_run++; if (imem_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
        tests_run++; if (inst !== 32'h0) begin tests_failed++; $display("FAIL reset_inst got=%h exp=0", inst); end
        tests_run++; if (inst_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_inst_pc got=%h exp=0", inst_pc); end
        tests_run++; if (misalign !== 1'b0) begin tests_failed++; $display("FAIL reset_misalign got=%b exp=0", misalign); end
    endtask

    // Three sequential fetches from a zero-wait memory; ends in HOLD at 0x8.
    task automatic test_zero_wait();
        rst = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            tests_run++; if (imem_req !== 1'b1) begin tests_failed++; $display("FAIL zw_req_issue[%0d] got=%b exp=1", i, imem_req); end
            tests_run++; if (imem_addr !== 32'(4 * i)) begin tests_failed++; $display("FAIL zw_addr[%0d] got=%h exp=%h", i, imem_addr, 4 * i); end
            imem_gnt = 1'b1;
            step();
            imem_gnt = 1'b0;
            tests_run++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin tests_failed++; $display("FAIL zw_wait[%0d] got req=%b valid=%b exp 0 0", i, imem_req, inst_valid); end
            imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
            step();
            imem_rvalid = 1'b0;
            tests_run++; if (inst_valid !== 1'b1 || imem_req !== 1'b0) begin tests_failed++; $display("FAIL zw_hold[%0d] got valid=%b req=%b exp 1 0", i, inst_valid, imem_req); end
            tests_run++; if (inst !== 32'h0000_0013) begin tests_failed++; $display("FAIL zw_inst[%0d] got=%h exp=00000013", i, inst); end
            tests_run++; if (inst_pc !== 32'(4 * i)) begin tests_failed++; $display("FAIL zw_inst_pc[%0d] got=%h exp=%h", i, inst_pc, 4 * i); end
            if (i < 2) begin
                inst_ready = 1'b1; npc = 32'(4 * i + 4);
                step();
                inst_ready = 1'b0;
            end
        end
    endtask

    task automatic test_branch();
        inst_ready = 1'b1; npc = 32'h0000_0040;
        step();
        inst_ready = 1'b0; npc = 32'h0;
        tests_run++; if (imem_addr !== 32'h40) begin tests_failed++; $display("FAIL br_addr got=%h exp=00000040", imem_addr); end
        tests_run++; if (pc !== 32'h40) begin tests_failed++; $display("FAIL br_pc got=%h exp=00000040", pc); end
        tests_run++; if (imem_req !== 1'b1 || inst_valid !== 1'b0) begin tests_failed++; $display("FAIL br_state got req=%b valid=%b exp 1 0", imem_req, inst_valid); end
    endtask

    // Fetch at 0x40, then hold decode off for 5 cycles.
    task automatic test_backpressure();
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hABCD_0001;
        step();
        imem_rvalid = 1'b0; imem_rdata = 32'h1111_1111;
        for (int i = 0; i < 5; i++) begin
            tests_run++; if (inst_valid !== 1'b1 || imem_req !== 1'b0) begin tests_failed++; $display("FAIL bp_state[%0d] got valid=%b req=%b exp 1 0", i, inst_valid, imem_req); end
            tests_run++; if (inst !== 32'hABCD_0001 || inst_pc !== 32'h40) begin tests_failed++; $display("FAIL bp_data[%0d] got inst=%h pc=%h exp abcd0001 00000040", i, inst, inst_pc); end
            npc = 32'h0000_0003; // garbage npc without ready must be ignored
            step();
        end
        inst_ready = 1'b1; npc = 32'h0000_0044;
        step();
        inst_ready = 1'b0;
        tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h44) begin tests_failed++; $display("FAIL bp_advance got req=%b addr=%h exp 1 00000044", imem_req, imem_addr); end
        tests_run++; if (misalign !== 1'b0) begin tests_failed++; $display("FAIL bp_misalign got=%b exp=0", misalign); end
    endtask

    // Grant withheld 4 cycles with a spurious rvalid, then rvalid 3 cycles after grant.
    task automatic test_mem_stall();
        for (int i = 0; i < 4; i++) begin
            imem_rvalid = (i == 1); imem_rdata = 32'hDEAD_BEEF;
            tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h44) begin tests_failed++; $display("FAIL ms_issue[%0d] got req=%b addr=%h exp 1 00000044", i, imem_req, imem_addr); end
            step();
        end
        imem_rvalid = 1'b0;
        tests_run++; if (inst !== 32'hABCD_0001) begin tests_failed++; $display("FAIL ms_spurious got=%h exp=abcd0001", inst); end
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tests_run++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin tests_failed++; $display("FAIL ms_wait[%0d] got req=%b valid=%b exp 0 0", i, imem_req, inst_valid); end
            step();
        end
        imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        step();
        imem_rvalid = 1'b0;
        tests_run++; if (inst_valid !== 1'b1 || inst !== 32'h0050_0093 || inst_pc !== 32'h44) begin tests_failed++; $display("FAIL ms_capture got valid=%b inst=%h pc=%h exp 1 00500093 00000044", inst_valid, inst, inst_pc); end
    endtask

    task automatic test_misaligned();
        inst_ready = 1'b1; npc = 32'h0000_0042;
        step();
        inst_ready = 1'b0;
        tests_run++; if (misalign !== 1'b1) begin tests_failed++; $display("FAIL ma_flag got=%b exp=1", misalign); end
        tests_run++; if (pc !== 32'h44) begin tests_failed++; $display("FAIL ma_pc got=%h exp=00000044", pc); end
        for (int i = 0; i < 4; i++) begin
            imem_gnt = 1'b1; imem_rvalid = 1'b1; inst_ready = 1'b1; npc = 32'h0000_0100;
            tests_run++; if (imem_req !== 1'b0 || inst_valid !== 1'b0 || misalign !== 1'b1) begin tests_failed++; $display("FAIL ma_quiet[%0d] got req=%b valid=%b mis=%b exp 0 0 1", i, imem_req, inst_valid, misalign); end
            step();
        end
        imem_gnt = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0;
        rst = 1'b1;
        step();
        tests_run++; if (misalign !== 1'b0 || pc !== 32'h0) begin tests_failed++; $display("FAIL ma_reset got mis=%b pc=%h exp 0 00000000", misalign, pc); end
        rst = 1'b0;
        step();
        tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin tests_failed++; $display("FAIL ma_restart got req=%b addr=%h exp 1 00000000", imem_req, imem_addr); end
    endtask

    task automatic test_reset_in_wait();
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
        step();
        imem_rvalid = 1'b0; inst_ready = 1'b1; npc = 32'h0000_0100;
        step();
        inst_ready = 1'b0; imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        tests_run++; if (pc !== 32'h100 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin tests_failed++; $display("FAIL rw_pre got pc=%h req=%b valid=%b exp 00000100 0 0", pc, imem_req, inst_valid); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests_run++; if (pc !== 32'h0 || inst !== 32'h0 || inst_pc !== 32'h0) begin tests_failed++; $display("FAIL rw_reset got pc=%h inst=%h ipc=%h exp 0 0 0", pc, inst, inst_pc); end
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0; // late response in IDLE
        step();
        tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin tests_failed++; $display("FAIL rw_issue got req=%b addr=%h valid=%b exp 1 0 0", imem_req, imem_addr, inst_valid); end
        step(); // rvalid still high in ISSUE, must be ignored
        imem_rvalid = 1'b0;
        tests_run++; if (inst !== 32'h0 || inst_valid !== 1'b0) begin tests_failed++; $display("FAIL rw_late got inst=%h valid=%b exp 0 0", inst, inst_valid); end
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
        step();
        imem_rvalid = 1'b0;
        tests_run++; if (inst_valid !== 1'b1 || inst !== 32'h13 || inst_pc !== 32'h0) begin tests_failed++; $display("FAIL rw_fetch got valid=%b inst=%h ipc=%h exp 1 00000013 0", inst_valid, inst, inst_pc); end
    endtask

    // Reset and decode handshake in the same cycle: reset takes priority.
    task automatic test_rst_and_ready();
        rst = 1'b1; inst_ready = 1'b1; npc = 32'h0000_0080;
        step();
        rst = 1'b0; inst_ready = 1'b0;
        tests_run++; if (pc !== 32'h0 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin tests_failed++; $display("FAIL rr_reset got pc=%h req=%b valid=%b exp 0 0 0", pc, imem_req, inst_valid); end
        step();
        tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin tests_failed++; $display("FAIL rr_restart got req=%b addr=%h exp 1 0", imem_req, imem_addr); end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_zero_wait();
        test_branch();
        test_backpressure();
        test_mem_stall();
        test_misaligned();
        test_reset_in_wait();
        test_rst_and_ready();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
